ram_param_sp: RTL

RAM_PARAM_SP -- requirements
Module: ram_param_sp

---
 rtl/ram_param_sp_if.sv | 27 ++
 rtl/ram_param_sp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ram_param_sp_if.sv
// ram_param_sp_if: access bus for the single-port parameterised RAM.
// The master drives the request fields; the slave returns the read word and status pulses.
interface ram_param_sp_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7
) ();
    logic              CS;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              busy;
    logic              err;
    logic              par_err;

    modport master (
        output CS, read, write, address, write_data,
        input  read_data, rd_valid, busy, err, par_err
    );

    modport slave (
        input  CS, read, write, address, write_data,
        output read_data, rd_valid, busy, err, par_err
    );
endinterface

// File: rtl/ram_param_sp.sv
// ram_param_sp: single-port RAM with a post-reset clear sweep and registered read port.
// After reset the array is zeroed one word per cycle (busy high); accesses are then accepted.
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per word and flag
// mismatches on read through par_err.
module ram_param_sp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7
) (
    input logic           clk,
    input logic           rst,
    ram_param_sp_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              rd_par_fail;

    logic              do_wr;
    logic              do_rd;
    logic              reject;

    logic [DATA_W-1:0] read_data_q;
    logic              rd_valid_q;
    logic              err_q;
    logic              par_err_q;

    assign rd_word = mem[bus.address];

`ifdef RAM_PARITY_EN
    // Parity bit sits above the data; an all-zero word (as left by the sweep) is consistent.
    assign wr_word     = {^bus.write_data, bus.write_data};
    assign rd_par_fail = ^rd_word;
`else
    assign wr_word     = bus.write_data;
    assign rd_par_fail = 1'b0;
`endif

    // Next-state logic: the sweep walks every address once, then parks in idle.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Access decode: simultaneous read+write, or any request during the sweep, is rejected.
    always_comb begin
        do_wr  = 1'b0;
        do_rd  = 1'b0;
        reject = 1'b0;
        if (bus.CS && (bus.read || bus.write)) begin
            if (state_q == StClear || (bus.read && bus.write)) begin
                reject = 1'b1;
            end else if (bus.write) begin
                do_wr = 1'b1;
            end else begin
                do_rd = 1'b1;
            end
        end
    end

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array; deliberately not reset so contents only become zero via the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem[clr_cnt_q] <= '0;
            end else if (do_wr) begin
                mem[bus.address] <= wr_word;
            end
        end
    end

    // Registered read port and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= do_rd;
            err_q      <= reject;
            par_err_q  <= do_rd && rd_par_fail;
            if (do_rd) begin
                read_data_q <= rd_word[DATA_W-1:0];
            end
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.err       = err_q;
    assign bus.par_err   = par_err_q;
    // Busy follows rst directly so it reads high for the whole reset window.
    assign bus.busy      = rst || (state_q == StClear);

endmodule
